rbus_uart_tx_pktparse: RTL and testbench
========================================

# rbus_uart_tx_pktparse

Ring-bus-to-UART transmit-side packet parser. Accepts 9-word write packets (header plus 8 data dwords with per-byte enables) addressed to the UART TX device. It stores one packet, then streams every enabled byte, in address order, to the UART transmitter over a strobe/ack byte handshake. It is the counterpart of the UART RX packet former: byte-lane and mask layout are identical, so one byte written by the RX side reappears here unchanged.

## Interface
Parameters: none; packet geometry is fixed at 1 header plus 8 data words.
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- r2d_stb  in  1  ring word valid
- r2d_sof  in  1  start of frame; marks the header word
- r2d_data  in  72  ring word
- r2d_rdy  out  2  both bits 1 iff the block can accept a whole new packet
- o_stb  out  1  byte valid to UART TX
- o_data  out  8  byte to UART TX
- o_ack  in  1  byte consumed; transfer on o_stb && o_ack
- o_pkt_addr  out  39  byte address of the last accepted packet, {hdr[38:3],3'b000}
- o_busy  out  1  state != IDLE

## Operation
- Header word: [71:70]=op, [39]=1, [38:3]=dword address, [2:0]=length code. [2:0] is not checked.
- Data word: [71:64]=byte-enable mask, [63:0]=bytes. Byte k uses mask bit 7-k and data [63-8k:56-8k], so byte 0 is [63:56] under mask 0x80.
- States: IDLE, LOAD, SKIP, DRAIN.
- IDLE:
  - r2d_rdy=2'b11.
  - Header with r2d_stb&&r2d_sof: if op==2'b10, latch o_pkt_addr, clear word counter wcnt(3b) and go to LOAD. Otherwise go to SKIP.
  - Words with stb=1 and sof=0 are ignored.
- LOAD:
  - Each r2d_stb word is written to buffer[wcnt] (8x72) and wcnt increments.
  - Cycles with stb low are gaps and are waited out.
  - On the 8th word (wcnt==7), clear byte pointer bptr(6b) and go to DRAIN.
  - A word with r2d_sof=1 in LOAD aborts the partial packet and is processed as a fresh IDLE header in the same cycle.
- SKIP: discard words until 8 stb data words have been counted, then go to IDLE. A sof word in SKIP is treated as in LOAD.
- DRAIN:
  - bptr[5:3] selects the dword and bptr[2:0] selects the byte.
  - o_stb = mask bit of the current byte (combinational from buffer and bptr). o_data = that byte.
  - bptr advances on o_stb&&o_ack, or unconditionally when the mask bit is 0 (one cycle per disabled byte).
  - When bptr==63 advances, go to IDLE.
  - r2d_stb words arriving in DRAIN are ignored; this is a sender protocol violation.
- o_data and o_stb hold stable while o_stb=1 and o_ack=0.
- Reset values: state=IDLE, wcnt=0, bptr=0, o_pkt_addr=0, o_stb=0, o_busy=0, r2d_rdy=2'b11 after the first reset edge. Buffer contents are don't-care.

## Timing
- r2d_rdy drops in the cycle after the header is accepted.
- First o_stb can assert in the cycle after the 8th data word, if byte 0 is enabled.
- Drain takes 64 cycles plus the ack stall cycles of enabled bytes. With all masks 0, IDLE returns 64 cycles after the last word.
- r2d_rdy returns to 2'b11 in the cycle after the final byte position is consumed.
- Reset mid-LOAD or mid-DRAIN: state is IDLE in the next cycle, o_stb=0, and the pending bytes are lost.
- A simultaneous header and last-byte ack cannot occur, because r2d_rdy is 0 in DRAIN.

## Test plan
- Single packet, op=2'b10, all masks 0xFF, bytes 0x00..0x3F, o_ack tied 1 -> 64 transfers in order 0x00..0x3F on consecutive cycles. r2d_rdy=2'b11 one cycle after the last one.
- RX-former style packet, dword d mask=0x80>>(d%8) with one byte each -> exactly 8 bytes output in dword order. o_pkt_addr equals the header address with [2:0]=0.
- Same as the first scenario, with o_ack asserted every 3rd cycle -> o_data stable while stalled, 64 bytes output, no byte lost or duplicated.
- Header op=2'b00 followed by 8 words -> no o_stb, block back in IDLE; a following valid packet is output normally.
- Valid header plus 3 words, then a new sof header plus 8 words -> only the second packet's bytes are output.
- rst pulsed during DRAIN after 10 bytes -> o_stb=0 next cycle, r2d_rdy=2'b11, and the next packet is output from byte 0.

Source files
------------

// File: rtl/rbus_uart_tx_pktparse_if.sv
// Ring-bus write port and UART TX byte handshake of the TX packet parser.
// The slave modport is the parser; the master modport is the ring/UART side.
interface rbus_uart_tx_pktparse_if;
  logic        r2d_stb;
  logic        r2d_sof;
  logic [71:0] r2d_data;
  logic [1:0]  r2d_rdy;
  logic        o_stb;
  logic [7:0]  o_data;
  logic        o_ack;
  logic [38:0] o_pkt_addr;
  logic        o_busy;

  modport slave (
    input  r2d_stb, r2d_sof, r2d_data, o_ack,
    output r2d_rdy, o_stb, o_data, o_pkt_addr, o_busy
  );

  modport master (
    output r2d_stb, r2d_sof, r2d_data, o_ack,
    input  r2d_rdy, o_stb, o_data, o_pkt_addr, o_busy
  );
endinterface

// File: rtl/rbus_uart_tx_pktparse.sv
// Stores one 9-word ring write packet for the UART TX device and streams its
// enabled bytes, in address order, over a strobe/ack byte handshake.
module rbus_uart_tx_pktparse (
  input logic                       clk,
  input logic                       rst,
  rbus_uart_tx_pktparse_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SKIP, DRAIN} state_t;

  state_t      state;
  logic [2:0]  wcnt;
  logic [5:0]  bptr;
  logic [38:0] pkt_addr;
  logic [71:0] buffer [8];

  logic [71:0] cur_word;
  logic [7:0]  cur_mask;
  logic [63:0] cur_bytes;
  logic        cur_en;
  logic [7:0]  cur_byte;
  logic        hdr;
  logic        hdr_ok;
  logic        dword;
  logic        advance;

  // Byte k sits under mask bit 7-k and at data bits [63-8k:56-8k]; 7-k == ~k.
  assign cur_word  = buffer[bptr[5:3]];
  assign cur_mask  = cur_word[71:64];
  assign cur_bytes = cur_word[63:0];
  assign cur_en    = cur_mask[~bptr[2:0]];
  assign cur_byte  = cur_bytes[{~bptr[2:0], 3'b000} +: 8];

  assign hdr     = bus.r2d_stb & bus.r2d_sof;
  assign hdr_ok  = (bus.r2d_data[71:70] == 2'b10);
  assign dword   = bus.r2d_stb & ~bus.r2d_sof;
  assign advance = ~cur_en | bus.o_ack;

  // A sof word restarts header processing from IDLE, LOAD or SKIP alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= 3'd0;
      bptr     <= 6'd0;
      pkt_addr <= 39'd0;
    end else begin
      case (state)
        IDLE, LOAD, SKIP: begin
          if (hdr) begin
            wcnt <= 3'd0;
            if (hdr_ok) begin
              pkt_addr <= {bus.r2d_data[38:3], 3'b000};
              state    <= LOAD;
            end else begin
              state <= SKIP;
            end
          end else if (dword && (state != IDLE)) begin
            wcnt <= wcnt + 3'd1;
            if (state == LOAD) begin
              buffer[wcnt] <= bus.r2d_data;
            end
            if (wcnt == 3'd7) begin
              bptr  <= 6'd0;
              state <= (state == LOAD) ? DRAIN : IDLE;
            end
          end
        end
        DRAIN: begin
          if (advance) begin
            bptr <= bptr + 6'd1;
            if (bptr == 6'd63) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r2d_rdy    = (state == IDLE) ? 2'b11 : 2'b00;
  assign bus.o_stb      = (state == DRAIN) & cur_en;
  assign bus.o_data     = cur_byte;
  assign bus.o_pkt_addr = pkt_addr;
  assign bus.o_busy     = (state != IDLE);

endmodule

// File: tb/tb_rbus_uart_tx_pktparse.sv
// Directed bench for the UART TX packet parser: ordering, stalls, skips,
// mid-packet restarts and reset during drain, all against hand-computed bytes.
module tb_rbus_uart_tx_pktparse;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [71:0] pkt [8];
  logic [7:0]  got [$];

  rbus_uart_tx_pktparse_if bus ();

  rbus_uart_tx_pktparse dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [71:0] hdr_word(input logic [1:0] op, input logic [35:0] addr,
                                           input logic [2:0] len);
    return {op, 30'd0, 1'b1, addr, len};
  endfunction

  // Word w, byte k carries base + 8w + k.
  task automatic fill_seq(input logic [7:0] base, input logic [7:0] mask);
    for (int w = 0; w < 8; w++) begin
      pkt[w][71:64] = mask;
      for (int k = 0; k < 8; k++) begin
        pkt[w][63-8*k -: 8] = 8'(base + 8'(8*w + k));
      end
    end
  endtask

  task automatic send_word(input logic sof, input logic [71:0] w);
    @(negedge clk);
    bus.r2d_stb  = 1'b1;
    bus.r2d_sof  = sof;
    bus.r2d_data = w;
  endtask

  task automatic send_packet(input logic [35:0] addr);
    send_word(1'b1, hdr_word(2'b10, addr, 3'b111));
    for (int i = 0; i < 8; i++) send_word(1'b0, pkt[i]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.r2d_stb = 1'b0;
      bus.r2d_sof = 1'b0;
    end
  endtask

  // Acks every ack_period-th cycle; stops at the first cycle with o_busy low.
  task automatic collect(input int ack_period, input int budget, output int cycles,
                         output int first_xfer, output int last_xfer,
                         output int stall_bad, output logic [1:0] rdy_end);
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       ack;
    got.delete();
    first_xfer = -1;
    last_xfer  = -1;
    stall_bad  = 0;
    prev_hold  = 1'b0;
    prev_data  = 8'h00;
    cycles     = budget;
    rdy_end    = 2'b00;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.r2d_stb = 1'b0;
      bus.r2d_sof = 1'b0;
      if (prev_hold && (!bus.o_stb || bus.o_data !== prev_data)) stall_bad++;
      if (!bus.o_busy) begin
        cycles  = c;
        rdy_end = bus.r2d_rdy;
        break;
      end
      ack = (ack_period <= 1) ? 1'b1 : ((c % ack_period) == ack_period - 1);
      bus.o_ack = ack;
      if (bus.o_stb && ack) begin
        got.push_back(bus.o_data);
        if (first_xfer < 0) first_xfer = c;
        last_xfer = c;
      end
      prev_hold = bus.o_stb && !ack;
      prev_data = bus.o_data;
    end
    bus.o_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_stb !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs o_stb=%b o_busy=%b required 0/0", bus.o_stb, bus.o_busy);
    end
    checks++;
    if (bus.r2d_rdy !== 2'b11) begin
      failures++;
      $display("[TB] FAIL reset_rdy got=%b required 11", bus.r2d_rdy);
    end
    checks++;
    if (bus.o_pkt_addr !== 39'd0) begin
      failures++;
      $display("[TB] FAIL reset_addr got=%h required 0", bus.o_pkt_addr);
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_single_packet();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    $display("[TB] single packet, ack tied high");
    fill_seq(8'h00, 8'hFF);
    send_word(1'b1, hdr_word(2'b10, 36'h0_0000_1234, 3'b000));
    send_word(1'b0, pkt[0]);
    checks++;
    if (bus.r2d_rdy !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rdy_drop got=%b required 00", bus.r2d_rdy);
    end
    for (int i = 1; i < 8; i++) send_word(1'b0, pkt[i]);
    collect(1, 300, cyc, first, last, sbad, rdy);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("[TB] FAIL single_count got=%0d required 64", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL single_byte[%0d] got=%h required %h", i, got[i], 8'(i));
      end
    end
    checks++;
    if (first != 0 || last != 63) begin
      failures++;
      $display("[TB] FAIL single_timing first=%0d last=%0d required 0/63", first, last);
    end
    checks++;
    if (cyc != 64 || rdy !== 2'b11) begin
      failures++;
      $display("[TB] FAIL single_idle cycle=%0d rdy=%b required 64/11", cyc, rdy);
    end
  endtask

  task automatic test_rx_style();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    $display("[TB] rx-former style one byte per dword");
    for (int d = 0; d < 8; d++) begin
      pkt[d] = {8'h80 >> d, {8{8'hEE}}};
      pkt[d][63-8*d -: 8] = 8'(8'hA0 + d);
    end
    send_word(1'b1, hdr_word(2'b10, 36'h9_8765_4321, 3'b101));
    for (int i = 0; i < 8; i++) send_word(1'b0, pkt[i]);
    collect(1, 300, cyc, first, last, sbad, rdy);
    checks++;
    if (got.size() != 8) begin
      failures++;
      $display("[TB] FAIL rx_count got=%0d required 8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'hA0 + i)) begin
        failures++;
        $display("[TB] FAIL rx_byte[%0d] got=%h required %h", i, got[i], 8'(8'hA0 + i));
      end
    end
    checks++;
    if (bus.o_pkt_addr !== {36'h9_8765_4321, 3'b000}) begin
      failures++;
      $display("[TB] FAIL rx_addr got=%h required %h", bus.o_pkt_addr, {36'h9_8765_4321, 3'b000});
    end
    checks++;
    if (cyc != 64) begin
      failures++;
      $display("[TB] FAIL rx_drain_len got=%0d required 64", cyc);
    end
  endtask

  task automatic test_stall();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    $display("[TB] ack every third cycle");
    fill_seq(8'h00, 8'hFF);
    send_packet(36'h0_0000_0042);
    collect(3, 600, cyc, first, last, sbad, rdy);
    checks++;
    if (cyc >= 600) begin
      failures++;
      $display("[TB] FAIL stall_timeout cycles=%0d required <600", cyc);
    end
    checks++;
    if (sbad != 0) begin
      failures++;
      $display("[TB] FAIL stall_hold unstable=%0d required 0", sbad);
    end
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("[TB] FAIL stall_count got=%0d required 64", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL stall_byte[%0d] got=%h required %h", i, got[i], 8'(i));
      end
    end
  endtask

  task automatic test_skip();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    int any_stb;
    $display("[TB] non-write header skipped");
    any_stb = 0;
    fill_seq(8'h55, 8'hFF);
    send_word(1'b1, hdr_word(2'b00, 36'h0_0000_0777, 3'b000));
    for (int i = 0; i < 8; i++) begin
      send_word(1'b0, pkt[i]);
      if (bus.o_stb) any_stb++;
    end
    idle_cycles(1);
    checks++;
    if (any_stb != 0 || bus.o_stb !== 1'b0) begin
      failures++;
      $display("[TB] FAIL skip_no_stb strobes=%0d o_stb=%b required 0", any_stb, bus.o_stb);
    end
    checks++;
    if (bus.o_busy !== 1'b0 || bus.r2d_rdy !== 2'b11) begin
      failures++;
      $display("[TB] FAIL skip_idle busy=%b rdy=%b required 0/11", bus.o_busy, bus.r2d_rdy);
    end
    fill_seq(8'h80, 8'hFF);
    send_packet(36'h0_0000_0100);
    collect(1, 300, cyc, first, last, sbad, rdy);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("[TB] FAIL skip_next_count got=%0d required 64", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'h80 + i)) begin
        failures++;
        $display("[TB] FAIL skip_next_byte[%0d] got=%h required %h", i, got[i], 8'(8'h80 + i));
      end
    end
  endtask

  task automatic test_abort();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    $display("[TB] partial packet replaced by new header");
    fill_seq(8'h40, 8'hFF);
    send_word(1'b1, hdr_word(2'b10, 36'h0_0000_0AAA, 3'b000));
    for (int i = 0; i < 3; i++) send_word(1'b0, pkt[i]);
    fill_seq(8'hC0, 8'hFF);
    send_packet(36'h0_0000_0BBB);
    collect(1, 300, cyc, first, last, sbad, rdy);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("[TB] FAIL abort_count got=%0d required 64", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'hC0 + i)) begin
        failures++;
        $display("[TB] FAIL abort_byte[%0d] got=%h required %h", i, got[i], 8'(8'hC0 + i));
      end
    end
    checks++;
    if (bus.o_pkt_addr !== {36'h0_0000_0BBB, 3'b000}) begin
      failures++;
      $display("[TB] FAIL abort_addr got=%h required %h", bus.o_pkt_addr, {36'h0_0000_0BBB, 3'b000});
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc, first, last, sbad;
    logic [1:0] rdy;
    int n;
    $display("[TB] reset during drain");
    fill_seq(8'h00, 8'hFF);
    send_packet(36'h0_0000_0321);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.r2d_stb = 1'b0;
      bus.r2d_sof = 1'b0;
      bus.o_ack   = 1'b1;
      if (bus.o_stb) n++;
    end
    @(negedge clk);
    bus.o_ack = 1'b0;
    rst = 1'b1;
    checks++;
    if (n != 10) begin
      failures++;
      $display("[TB] FAIL pre_reset_bytes got=%0d required 10", n);
    end
    @(negedge clk);
    checks++;
    if (bus.o_stb !== 1'b0 || bus.o_busy !== 1'b0 || bus.r2d_rdy !== 2'b11) begin
      failures++;
      $display("[TB] FAIL drain_reset o_stb=%b busy=%b rdy=%b required 0/0/11",
               bus.o_stb, bus.o_busy, bus.r2d_rdy);
    end
    rst = 1'b0;
    fill_seq(8'h40, 8'hFF);
    send_packet(36'h0_0000_0654);
    collect(1, 300, cyc, first, last, sbad, rdy);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("[TB] FAIL post_reset_count got=%0d required 64", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'h40 + i)) begin
        failures++;
        $display("[TB] FAIL post_reset_byte[%0d] got=%h required %h", i, got[i], 8'(8'h40 + i));
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.r2d_stb  = 1'b0;
    bus.r2d_sof  = 1'b0;
    bus.r2d_data = 72'd0;
    bus.o_ack    = 1'b0;
    test_reset();
    test_single_packet();
    test_rx_style();
    test_stall();
    test_skip();
    test_abort();
    test_reset_mid_drain();
    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
